otter_mem2_arbiter: RTL
=======================

OTTER_MEM2_ARBITER -- requirements
Module: otter_mem2_arbiter

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-003 SHALL have pipeline-side inputs P_REQ 1, P_WE 1, P_ADDR 32, P_DIN 32, P_SIZE 2, P_SIGN 1; these carry the MEM-stage access request.
REQ-004 SHALL have programmer-side inputs G_REQ 1, G_WE 1, G_ADDR 32, G_DIN 32, G_LOCK 1; G_LOCK means the programmer burst is in progress.
REQ-005 SHALL have outputs P_GNT 1, P_STALL 1, P_RVALID 1, G_GNT 1, G_RVALID 1, RDATA 32; RDATA is the returned read data, shared by both requesters.
REQ-006 SHALL have memory-side outputs M_ADDR 32, M_DIN 32, M_WE 1, M_RE 1, M_SIZE 2, M_SIGN 1, and memory-side input M_DOUT 32; the memory is synchronous with 1-cycle read latency.

Function
REQ-007 SHALL implement owner FSM states IDLE, PIPE, PROG; the state records the last granted requester, or none.
REQ-008 SHALL grant at most one requester per cycle; grant is combinational in the same cycle as REQ.
REQ-009 SHALL grant G when G_REQ=1 and P_REQ=0, and grant P when P_REQ=1 and G_REQ=0.
REQ-010 SHALL resolve G_REQ=P_REQ=1 by fixed priority to G (default build).
REQ-011 SHALL keep ownership with G while state=PROG and G_LOCK=1, whether or not G_REQ is asserted; P is not granted during that time.
REQ-012 SHALL move the FSM as follows each cycle:
- to PROG on a G grant;
- to PIPE on a P grant;
- to IDLE when there is no grant and G_LOCK=0.
REQ-013 SHALL drive M_* from the granted requester's fields.
- G forces M_SIZE=2'b10 and M_SIGN=0.
- M_WE=granted WE; M_RE=granted & ~WE.
- With no grant: M_WE=0 and M_RE=0; M_ADDR, M_DIN, M_SIZE and M_SIGN hold 0.
REQ-014 SHALL assert P_STALL=P_REQ & ~P_GNT in the same cycle.
REQ-015 SHALL register a pending-read tag (valid, owner) on each granted read.
REQ-016 SHALL assert P_RVALID or G_RVALID for exactly one cycle, the cycle after the granted read, with RDATA=M_DOUT; otherwise RDATA=0.
REQ-017 SHALL support back-to-back reads, including alternating owners, at one grant per cycle; each RVALID is attributed to the correct owner.
REQ-018 SHALL produce no RVALID for writes.
REQ-019 SHALL keep a write granted in the same cycle as a pending read's return from affecting RDATA or the RVALID attribution.
REQ-020 SHALL, when G_LOCK falls in the same cycle as P_REQ=1 and G_REQ=0, grant P in that cycle.
REQ-021 SHALL grant G when G_REQ and G_LOCK rise while state=PIPE, per REQ-010; no partially issued access exists, so none is dropped.

Reset
REQ-022 SHALL, while RESET=0, force the following:
- state=IDLE, pending tag cleared, RR pointer=G;
- all GNT, RVALID, M_WE and M_RE = 0;
- RDATA=0 and all M_* = 0;
- P_STALL=P_REQ.
REQ-023 SHALL issue no RVALID after RESET deasserts for a read granted before reset was asserted.

Configuration
REQ-024 SHALL use macro OTTER_MEM2_ARB_RR_EN to select the arbitration policy for simultaneous G_REQ and P_REQ.
- Defined: a 1-bit pointer alternates priority, and the requester not granted last wins; the pointer updates only on a contended grant; G_LOCK ownership (REQ-011) still overrides.
- Undefined: fixed G priority (REQ-010) and no pointer flop.

Verification
REQ-025 SHALL cover: P read, addr 0x100, M_DOUT 0xDEADBEEF -> P_GNT same cycle, M_RE=1, P_RVALID next cycle with RDATA=0xDEADBEEF.
REQ-026 SHALL cover: G_REQ=P_REQ=1 for 4 cycles with G_LOCK=0.
- Default: G granted all 4 cycles, P_STALL=1 for 4 cycles.
- RR_EN: grants G,P,G,P.
REQ-027 SHALL cover: G_LOCK=1 with G_REQ pulsed every 3rd cycle and P_REQ held high -> P_GNT=0 and P_STALL=1 throughout; P granted in the cycle G_LOCK falls.
REQ-028 SHALL cover: alternating reads G@0x0, P@0x4, G@0x8 -> G_RVALID, P_RVALID, G_RVALID on consecutive cycles with matching data.
REQ-029 SHALL cover: RESET asserted the cycle after a granted P read -> no P_RVALID; all outputs 0 while RESET=0, except P_STALL=P_REQ.
REQ-030 SHALL cover: G write 0x12345678 to 0x2000 with P_SIZE=0 presented -> M_SIZE=2'b10, M_SIGN=0, M_WE=1, no RVALID.

Source files
------------

// File: rtl/otter_mem2_arbiter.sv
// otter_mem2_arbiter: two-requester arbiter in front of one synchronous memory
// with a 1-cycle read latency. The pipeline (P) side issues MEM-stage accesses.
// The programmer (G) side issues word accesses and can hold ownership with
// G_LOCK during a burst.
//
// Ports
//   CLK, RESET                     clock, async active-low reset
//   P_REQ/WE/ADDR/DIN/SIZE/SIGN    pipeline request
//   G_REQ/WE/ADDR/DIN, G_LOCK      programmer request, burst lock
//   P_GNT, P_STALL, G_GNT          same-cycle grant/stall
//   P_RVALID, G_RVALID, RDATA      read return, one cycle after grant
//   M_ADDR/DIN/WE/RE/SIZE/SIGN     memory command, M_DOUT memory read data
//
// Configuration: define OTTER_MEM2_ARB_RR_EN for round-robin arbitration of
// simultaneous requests. By default G has fixed priority.
module otter_mem2_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        P_REQ,
  input  logic        P_WE,
  input  logic [31:0] P_ADDR,
  input  logic [31:0] P_DIN,
  input  logic [1:0]  P_SIZE,
  input  logic        P_SIGN,
  input  logic        G_REQ,
  input  logic        G_WE,
  input  logic [31:0] G_ADDR,
  input  logic [31:0] G_DIN,
  input  logic        G_LOCK,
  output logic        P_GNT,
  output logic        P_STALL,
  output logic        P_RVALID,
  output logic        G_GNT,
  output logic        G_RVALID,
  output logic [31:0] RDATA,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_DIN,
  output logic        M_WE,
  output logic        M_RE,
  output logic [1:0]  M_SIZE,
  output logic        M_SIGN,
  input  logic [31:0] M_DOUT
);

  typedef enum logic [1:0] {IDLE, PIPE, PROG} state_t;

  localparam logic OWN_P = 1'b0;
  localparam logic OWN_G = 1'b1;

  state_t state;
  logic   pend_valid;
  logic   pend_owner;
  logic   lock_hold;
  logic   g_prio;
  logic   g_gnt;
  logic   p_gnt;

`ifdef OTTER_MEM2_ARB_RR_EN
  // Priority pointer: 0 gives G priority, 1 gives P priority.
  logic rr_ptr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr_ptr <= 1'b0;
    end else if (G_REQ && P_REQ && (g_gnt || p_gnt)) begin
      rr_ptr <= g_gnt;
    end
  end

  assign g_prio = ~rr_ptr;
`else
  assign g_prio = 1'b1;
`endif

  // Grant decision; a locked programmer burst shuts out the pipeline.
  always_comb begin
    lock_hold = (state == PROG) && G_LOCK;
    g_gnt     = RESET && G_REQ && (lock_hold || !P_REQ || g_prio);
    p_gnt     = RESET && P_REQ && !lock_hold && !g_gnt;
  end

  // Owner FSM and pending-read tag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_owner <= OWN_G;
    end else begin
      if (g_gnt) begin
        state <= PROG;
      end else if (p_gnt) begin
        state <= PIPE;
      end else if (!G_LOCK) begin
        state <= IDLE;
      end
      pend_valid <= (g_gnt && !G_WE) || (p_gnt && !P_WE);
      pend_owner <= g_gnt ? OWN_G : OWN_P;
    end
  end

  // Memory command mux, grant/stall flags and read return.
  always_comb begin
    M_ADDR   = 32'd0;
    M_DIN    = 32'd0;
    M_WE     = 1'b0;
    M_RE     = 1'b0;
    M_SIZE   = 2'b00;
    M_SIGN   = 1'b0;
    G_GNT    = g_gnt;
    P_GNT    = p_gnt;
    P_STALL  = P_REQ && !p_gnt;
    P_RVALID = 1'b0;
    G_RVALID = 1'b0;
    RDATA    = 32'd0;

    if (g_gnt) begin
      M_ADDR = G_ADDR;
      M_DIN  = G_DIN;
      M_WE   = G_WE;
      M_RE   = !G_WE;
      M_SIZE = 2'b10;
      M_SIGN = 1'b0;
    end else if (p_gnt) begin
      M_ADDR = P_ADDR;
      M_DIN  = P_DIN;
      M_WE   = P_WE;
      M_RE   = !P_WE;
      M_SIZE = P_SIZE;
      M_SIGN = P_SIGN;
    end

    // The tag flops clear asynchronously, so the return is silent in reset.
    if (pend_valid) begin
      RDATA    = M_DOUT;
      P_RVALID = (pend_owner == OWN_P);
      G_RVALID = (pend_owner == OWN_G);
    end
  end

endmodule
